shift_reg_univ: RTL and testbench
=================================

# shift_reg_univ

Parametrised universal shift register, successor to the basic hold/shift/load register. Generalises the data path to N bits shifted S bits per step. Adds left shift, rotate and arithmetic shift modes, plus a self-timed burst serialiser (load, then stream N/S chunks LSB-first with busy/valid/done). Sits between parallel data paths and narrow serial links, or serves as a general datapath shifter.

## Interface
- N, default 8, register width in bits; N ≥ 2.
- S, default 1, bits shifted per step; 1 ≤ S < N, N % S == 0 (elaboration error otherwise).
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- op  in  3  operation select (see Operation); ignored while busy.
- d  in  N  parallel load data (LOAD and burst start).
- s_in_r  in  S  fill bits entering at MSB side on SHR and on burst shifts.
- s_in_l  in  S  fill bits entering at LSB side on SHL.
- start  in  1  burst request, sampled when busy=0.
- q  out  N  register contents.
- s_out_r  out  S  q[S-1:0], combinational from q.
- s_out_l  out  S  q[N-1:N-S], combinational from q.
- busy  out  1  burst in progress.
- ser_valid  out  1  s_out_r holds a valid burst chunk; equal to busy.
- done  out  1  one-cycle pulse after the last burst chunk.

## Operation
- Reset (rst_n=0 at an edge): q=0, busy=0, done=0, chunk counter=0. Reset has priority over everything, including mid-burst.
- Idle (busy=0), start=1: q<=d, counter<=N/S, busy<=1; op ignored that cycle.
- Idle, start=0, op decoded:
  - 000 HOLD: q unchanged.
  - 001 SHR: q<={s_in_r, q[N-1:S]}.
  - 010 LOAD: q<=d.
  - 011 SHL: q<={q[N-S-1:0], s_in_l}.
  - 100 ROR: q<={q[S-1:0], q[N-1:S]}.
  - 101 ROL: q<={q[N-S-1:0], q[N-1:N-S]}.
  - 110 ASR: q<={S copies of q[N-1], q[N-1:S]}.
  - 111 reserved: behaves as HOLD.
- Burst (busy=1): every edge performs SHR with s_in_r, counter decrements. Edge where counter goes 1->0: busy<=0, done<=1. op and start are ignored throughout.
- done is high for exactly one cycle, the first idle cycle. A start in that cycle is accepted (back-to-back bursts, done and new busy coexist).
- After a burst, q holds the N/S s_in_r chunks shifted in, with the last chunk in q[N-1:N-S].

## Timing
- Latency: all ops are visible on q one edge after sampling. s_out_r and s_out_l follow q combinationally.
- Burst accepted at edge k:
  - busy=1 from after edge k through after edge k+N/S-1, i.e. N/S cycles.
  - During cycle k+i (i=0..N/S-1), s_out_r = d[S*i+S-1:S*i].
  - done=1 in cycle k+N/S only.
- Minimum burst period: N/S cycles (restart in the done cycle).
- Reset asserted mid-burst: q, busy and done are 0 after that edge. No done pulse is produced for the aborted burst.

## Test plan
- Reset: rst_n=0 for 2 edges with op=010, d=FF, start=1 -> q=00, busy=0, done=0; outputs stay 0 until first post-reset op.
- Mode sweep (N=8, S=1): LOAD A5 -> A5; SHR s_in_r=1 -> D2; SHL s_in_l=1 -> A5; ROR -> D2; ROL -> A5; LOAD 81, ASR -> C0; op=111 -> C0 held; HOLD -> C0. Cross-check every edge against a reference model.
- Burst S=1: start with d=B4, s_in_r=0.
  - ser_valid high 8 cycles; s_out_r = 0,0,1,0,1,1,0,1.
  - done in 9th cycle only; q=00 after.
  - op=010, d=FF and start pulses during busy have no effect.
- Burst S=2 (N=8): start with d=C6, s_in_r=3.
  - s_out_r = 2,1,0,3 over 4 busy cycles; done in cycle 5; q=FF.
  - Start asserted in the done cycle with d=1B -> new burst, s_out_r = 3,2,1,0.
- Reset mid-burst: assert rst_n=0 in 3rd busy cycle of a d=B4 burst -> next cycle q=00, busy=0, ser_valid=0; done never pulses for that burst.
- Width generality: N=16, S=4, SHL s_in_l=F on 0000 four times -> FFFF; ROR once on 1234 -> 4123.

Source files
------------

// File: rtl/shift_reg_univ.sv
`default_nettype none
// ============================================================================
// Module      : shift_reg_univ
// Description : Parametrised universal shift register. N-bit register moved S
//               bits per step with hold, logical shift right/left, load,
//               rotate right/left and arithmetic shift right. A self-timed
//               burst serialiser loads d and streams N/S chunks LSB-first on
//               s_out_r, flagged by busy/ser_valid, followed by a one-cycle
//               done pulse.
// Ports       : clk        - clock, all state on rising edge
//               rst_n      - synchronous active-low reset
//               op[2:0]    - operation select, ignored while busy
//               d[N-1:0]   - parallel load / burst data
//               s_in_r     - S fill bits entering at the MSB side (SHR, burst)
//               s_in_l     - S fill bits entering at the LSB side (SHL)
//               start      - burst request, sampled when idle
//               q          - register contents
//               s_out_r    - q[S-1:0]
//               s_out_l    - q[N-1:N-S]
//               busy       - burst in progress
//               ser_valid  - s_out_r holds a valid burst chunk (== busy)
//               done       - one-cycle pulse in the first idle cycle after
//                            a burst
// Revision    : 1.0 - initial release
// ============================================================================
module shift_reg_univ #(
    parameter int N = 8,
    parameter int S = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [2:0]   op,
    input  logic [N-1:0] d,
    input  logic [S-1:0] s_in_r,
    input  logic [S-1:0] s_in_l,
    input  logic         start,
    output logic [N-1:0] q,
    output logic [S-1:0] s_out_r,
    output logic [S-1:0] s_out_l,
    output logic         busy,
    output logic         ser_valid,
    output logic         done
);

    localparam int C_CHUNKS = N / S;
    localparam int C_CNT_W  = $clog2(C_CHUNKS + 1);

    localparam logic [2:0] C_OP_HOLD = 3'b000;
    localparam logic [2:0] C_OP_SHR  = 3'b001;
    localparam logic [2:0] C_OP_LOAD = 3'b010;
    localparam logic [2:0] C_OP_SHL  = 3'b011;
    localparam logic [2:0] C_OP_ROR  = 3'b100;
    localparam logic [2:0] C_OP_ROL  = 3'b101;
    localparam logic [2:0] C_OP_ASR  = 3'b110;

    generate
        if ((N < 2) || (S < 1) || (S >= N) || ((N % S) != 0)) begin : g_bad_params
            $error("shift_reg_univ: illegal N/S combination");
        end
    endgenerate

    logic [N-1:0]       r_q;
    logic               r_busy;
    logic               r_done;
    logic [C_CNT_W-1:0] r_cnt;

    logic [N-1:0]       w_shr;
    logic [N-1:0]       w_op_next;

    // The burst path reuses the SHR result so streaming and a plain SHR
    // can never disagree on fill placement.
    assign w_shr = {s_in_r, r_q[N-1:S]};

    always_comb begin
        w_op_next = r_q;
        case (op)
            C_OP_HOLD: w_op_next = r_q;
            C_OP_SHR:  w_op_next = w_shr;
            C_OP_LOAD: w_op_next = d;
            C_OP_SHL:  w_op_next = {r_q[N-S-1:0], s_in_l};
            C_OP_ROR:  w_op_next = {r_q[S-1:0], r_q[N-1:S]};
            C_OP_ROL:  w_op_next = {r_q[N-S-1:0], r_q[N-1:N-S]};
            C_OP_ASR:  w_op_next = {{S{r_q[N-1]}}, r_q[N-1:S]};
            default:   w_op_next = r_q;   // 111 reserved, treated as hold
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q    <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_done <= 1'b0;
            if (r_busy) begin
                r_q   <= w_shr;
                r_cnt <= r_cnt - C_CNT_W'(1);
                // Last chunk has been presented this cycle; next cycle is idle.
                if (r_cnt == C_CNT_W'(1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end else if (start) begin
                r_q    <= d;
                r_cnt  <= C_CNT_W'(C_CHUNKS);
                r_busy <= 1'b1;
            end else begin
                r_q <= w_op_next;
            end
        end
    end

    assign q         = r_q;
    assign s_out_r   = r_q[S-1:0];
    assign s_out_l   = r_q[N-1:N-S];
    assign busy      = r_busy;
    assign ser_valid = r_busy;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_shift_reg_univ.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_reg_univ
// Description : Bench for shift_reg_univ. Three instances (N=8/S=1, N=8/S=2,
//               N=16/S=4) run against an arithmetic reference model, with
//               directed sequences pinned by literal values and a randomized
//               phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_reg_univ;

    localparam int NP [3] = '{8, 8, 16};
    localparam int SP [3] = '{1, 2, 4};

    logic clk;
    int   checks = 0;
    int   errors = 0;
    bit   cmp_en = 0;

    logic [2:0]  op [3];
    logic [15:0] d  [3];
    logic [3:0]  sr [3];
    logic [3:0]  sl [3];
    logic        st [3];
    logic        rn [3];

    logic [15:0] qv  [3];
    logic [3:0]  sor [3];
    logic [3:0]  sol [3];
    logic        bz  [3];
    logic        vl  [3];
    logic        dn  [3];

    logic [7:0]  q0, q1;
    logic [15:0] q2;
    logic [0:0]  sor0, sol0;
    logic [1:0]  sor1, sol1;
    logic [3:0]  sor2, sol2;

    shift_reg_univ #(.N(8), .S(1)) u_dut0 (
        .clk(clk), .rst_n(rn[0]), .op(op[0]), .d(d[0][7:0]),
        .s_in_r(sr[0][0:0]), .s_in_l(sl[0][0:0]), .start(st[0]),
        .q(q0), .s_out_r(sor0), .s_out_l(sol0),
        .busy(bz[0]), .ser_valid(vl[0]), .done(dn[0])
    );
    shift_reg_univ #(.N(8), .S(2)) u_dut1 (
        .clk(clk), .rst_n(rn[1]), .op(op[1]), .d(d[1][7:0]),
        .s_in_r(sr[1][1:0]), .s_in_l(sl[1][1:0]), .start(st[1]),
        .q(q1), .s_out_r(sor1), .s_out_l(sol1),
        .busy(bz[1]), .ser_valid(vl[1]), .done(dn[1])
    );
    shift_reg_univ #(.N(16), .S(4)) u_dut2 (
        .clk(clk), .rst_n(rn[2]), .op(op[2]), .d(d[2]),
        .s_in_r(sr[2]), .s_in_l(sl[2]), .start(st[2]),
        .q(q2), .s_out_r(sor2), .s_out_l(sol2),
        .busy(bz[2]), .ser_valid(vl[2]), .done(dn[2])
    );

    assign qv[0]  = {8'h00, q0};
    assign qv[1]  = {8'h00, q1};
    assign qv[2]  = q2;
    assign sor[0] = {3'b000, sor0};
    assign sor[1] = {2'b00, sor1};
    assign sor[2] = sor2;
    assign sol[0] = {3'b000, sol0};
    assign sol[1] = {2'b00, sol1};
    assign sol[2] = sol2;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ------------------------------------------------------------------
    // Reference model: register value as an integer, shifts as arithmetic
    // ------------------------------------------------------------------
    logic [15:0] mq [3];
    bit          mb [3];
    bit          md [3];
    int          mc [3];

    function automatic logic [15:0] wmask(int w);
        logic [16:0] one;
        one = 17'd1;
        return 16'((one << w) - 17'd1);
    endfunction

    function automatic logic [15:0] model_op(int n, int s, logic [2:0] o,
                                             logic [15:0] q, logic [15:0] dd,
                                             logic [15:0] r, logic [15:0] l);
        logic [15:0] m, fm, res;
        m   = wmask(n);
        fm  = wmask(s);
        res = q;
        case (o)
            3'd1: res = (q >> s) | ((r & fm) << (n - s));
            3'd2: res = dd;
            3'd3: res = (q << s) | (l & fm);
            3'd4: res = (q >> s) | (q << (n - s));
            3'd5: res = (q << s) | (q >> (n - s));
            3'd6: res = (q >> s) | (q[n-1] ? (m & ~(m >> s)) : 16'h0);
            default: res = q;
        endcase
        return res & m;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!rn[k]) begin
                mq[k] = '0; mb[k] = 0; md[k] = 0; mc[k] = 0;
            end else begin
                md[k] = 0;
                if (mb[k]) begin
                    mq[k] = model_op(NP[k], SP[k], 3'd1, mq[k], d[k], {12'h0, sr[k]}, {12'h0, sl[k]});
                    mc[k] = mc[k] - 1;
                    if (mc[k] == 0) begin
                        mb[k] = 0;
                        md[k] = 1;
                    end
                end else if (st[k]) begin
                    mq[k] = d[k] & wmask(NP[k]);
                    mc[k] = NP[k] / SP[k];
                    mb[k] = 1;
                end else begin
                    mq[k] = model_op(NP[k], SP[k], op[k], mq[k], d[k], {12'h0, sr[k]}, {12'h0, sl[k]});
                end
            end
        end
    end

    task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Per-cycle comparison of every instance against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("model_q%0d", k), qv[k], mq[k]);
                chk($sformatf("model_busy%0d", k), {15'h0, bz[k]}, {15'h0, mb[k]});
                chk($sformatf("model_valid%0d", k), {15'h0, vl[k]}, {15'h0, mb[k]});
                chk($sformatf("model_done%0d", k), {15'h0, dn[k]}, {15'h0, md[k]});
                chk($sformatf("model_sor%0d", k), {12'h0, sor[k]}, mq[k] & wmask(SP[k]));
                chk($sformatf("model_sol%0d", k), {12'h0, sol[k]},
                    (mq[k] >> (NP[k] - SP[k])) & wmask(SP[k]));
            end
        end
    end

    task automatic set_in(int k, logic [2:0] o, logic [15:0] dd,
                          logic [3:0] r, logic [3:0] l, logic s);
        op[k] = o; d[k] = dd; sr[k] = r; sl[k] = l; st[k] = s;
    endtask

    task automatic do_op(int k, logic [2:0] o, logic [15:0] dd, logic [3:0] r,
                         logic [3:0] l, logic [15:0] exp, string nm);
        set_in(k, o, dd, r, l, 1'b0);
        @(negedge clk);
        chk(nm, qv[k], exp);
    endtask

    logic [3:0] exp_c [4];
    logic [7:0] b4;

    initial begin
        // Reset with every competing input active
        for (int k = 0; k < 3; k++) begin
            rn[k] = 1'b0;
            set_in(k, 3'd2, 16'hFFFF, 4'h0, 4'h0, 1'b1);
        end
        @(negedge clk);
        cmp_en = 1;
        @(negedge clk);
        chk("rst_q0", qv[0], 16'h0000);
        chk("rst_busy0", {15'h0, bz[0]}, 16'h0);
        chk("rst_done0", {15'h0, dn[0]}, 16'h0);
        chk("rst_q2", qv[2], 16'h0000);
        for (int k = 0; k < 3; k++) begin
            rn[k] = 1'b1;
            set_in(k, 3'd0, 16'h0, 4'h0, 4'h0, 1'b0);
        end
        @(negedge clk);
        chk("post_rst_q0", qv[0], 16'h0000);

        // Mode sweep, N=8 S=1
        do_op(0, 3'd2, 16'hA5, 4'h0, 4'h0, 16'hA5, "sweep_load");
        do_op(0, 3'd1, 16'h00, 4'h1, 4'h0, 16'hD2, "sweep_shr");
        do_op(0, 3'd3, 16'h00, 4'h0, 4'h1, 16'hA5, "sweep_shl");
        do_op(0, 3'd4, 16'h00, 4'h0, 4'h0, 16'hD2, "sweep_ror");
        do_op(0, 3'd5, 16'h00, 4'h0, 4'h0, 16'hA5, "sweep_rol");
        do_op(0, 3'd2, 16'h81, 4'h0, 4'h0, 16'h81, "sweep_load81");
        do_op(0, 3'd6, 16'h00, 4'h0, 4'h0, 16'hC0, "sweep_asr");
        do_op(0, 3'd7, 16'h00, 4'h0, 4'h0, 16'hC0, "sweep_rsvd");
        do_op(0, 3'd0, 16'h00, 4'h0, 4'h0, 16'hC0, "sweep_hold");

        // Burst S=1, d=B4, with ignored op/start noise while busy
        b4 = 8'hB4;
        set_in(0, 3'd0, 16'hB4, 4'h0, 4'h0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("b1_valid", {15'h0, vl[0]}, 16'h0001);
            chk("b1_sor", {12'h0, sor[0]}, {15'h0, b4[i]});
            set_in(0, 3'd2, 16'hFF, 4'h0, 4'h0, 1'($urandom_range(0, 1)));
        end
        set_in(0, 3'd0, 16'h0, 4'h0, 4'h0, 1'b0);
        @(negedge clk);
        chk("b1_done", {15'h0, dn[0]}, 16'h0001);
        chk("b1_busy_end", {15'h0, bz[0]}, 16'h0000);
        chk("b1_q", qv[0], 16'h0000);
        @(negedge clk);
        chk("b1_done_once", {15'h0, dn[0]}, 16'h0000);

        // Burst S=2, d=C6 fill 3, then back-to-back d=1B
        exp_c = '{4'd2, 4'd1, 4'd0, 4'd3};
        set_in(1, 3'd0, 16'hC6, 4'h3, 4'h0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("b2_sor", {12'h0, sor[1]}, {12'h0, exp_c[i]});
            st[1] = 1'b0;
        end
        @(negedge clk);
        chk("b2_done", {15'h0, dn[1]}, 16'h0001);
        chk("b2_q", qv[1], 16'h00FF);
        set_in(1, 3'd0, 16'h1B, 4'h3, 4'h0, 1'b1);
        exp_c = '{4'd3, 4'd2, 4'd1, 4'd0};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("b2b_busy", {15'h0, bz[1]}, 16'h0001);
            chk("b2b_sor", {12'h0, sor[1]}, {12'h0, exp_c[i]});
            st[1] = 1'b0;
        end
        @(negedge clk);
        chk("b2b_done", {15'h0, dn[1]}, 16'h0001);
        chk("b2b_q", qv[1], 16'h00FF);

        // Reset in the third busy cycle of a d=B4 burst
        set_in(0, 3'd0, 16'hB4, 4'h0, 4'h0, 1'b1);
        @(negedge clk);
        st[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_busy_before", {15'h0, bz[0]}, 16'h0001);
        rn[0] = 1'b0;
        @(negedge clk);
        chk("abort_q", qv[0], 16'h0000);
        chk("abort_busy", {15'h0, bz[0]}, 16'h0000);
        chk("abort_valid", {15'h0, vl[0]}, 16'h0000);
        rn[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("abort_no_done", {15'h0, dn[0]}, 16'h0000);
        end

        // Width generality, N=16 S=4
        do_op(2, 3'd2, 16'h0000, 4'h0, 4'h0, 16'h0000, "w16_clear");
        do_op(2, 3'd3, 16'h0000, 4'h0, 4'hF, 16'h000F, "w16_shl1");
        do_op(2, 3'd3, 16'h0000, 4'h0, 4'hF, 16'h00FF, "w16_shl2");
        do_op(2, 3'd3, 16'h0000, 4'h0, 4'hF, 16'h0FFF, "w16_shl3");
        do_op(2, 3'd3, 16'h0000, 4'h0, 4'hF, 16'hFFFF, "w16_shl4");
        do_op(2, 3'd2, 16'h1234, 4'h0, 4'h0, 16'h1234, "w16_load");
        do_op(2, 3'd4, 16'h0000, 4'h0, 4'h0, 16'h4123, "w16_ror");
        do_op(2, 3'd6, 16'h0000, 4'h0, 4'h0, 16'h0412, "w16_asr_pos");

        // Randomized phase, all instances, occasional reset and bursts
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < 3; k++) begin
                rn[k] = ($urandom_range(0, 39) != 0);
                set_in(k, 3'($urandom), 16'($urandom), 4'($urandom), 4'($urandom),
                       ($urandom_range(0, 7) == 0));
            end
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
